// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack: default sizing and the
// push/pop operation decode.
package ras_pkg;

    localparam int unsigned RAS_DEPTH = 8;
    localparam int unsigned RAS_WIDTH = 32;
    localparam int unsigned PTR_W     = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } ras_op_t;

    // Map the raw {push, pop} strobes onto a named operation.
    function automatic ras_op_t decode_op(input logic push, input logic pop);
        ras_op_t op;
        unique case ({push, pop})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = REPLACE;
            default: op = NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ras_storage.sv
// DEPTH x WIDTH register array for the return-address stack: one synchronous
// write port, one asynchronous read port, all entries reset to zero.
module ras_storage
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned WIDTH = RAS_WIDTH,
    parameter int unsigned PtrW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [PtrW-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PtrW-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Entry array: cleared on reset, one entry written per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: JAL pushes its link value, a return pops it. The top
// entry is exposed combinationally from registered state only, so PushAddr
// never reaches TopAddr in the same cycle.
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned WIDTH = RAS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_addr,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_top_addr,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  r_sp;
    logic [CntW-1:0]  r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [PtrW-1:0]  w_sp_nxt;
    logic [CntW-1:0]  w_count_nxt;
    logic             w_overflow_nxt;
    logic             w_underflow_nxt;
    logic [PtrW-1:0]  w_sp_m1;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [PtrW-1:0]  w_waddr;
    logic [WIDTH-1:0] w_rdata;
    ras_op_t          w_op;

    ras_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PtrW  (PtrW)
    ) u_storage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_push_addr),
        .i_raddr (w_sp_m1),
        .o_rdata (w_rdata)
    );

    // Status decode from registered state.
    always_comb begin
        w_op    = decode_op(i_push, i_pop);
        w_sp_m1 = r_sp - PtrW'(1);
        w_empty = (r_count == '0);
        w_full  = (r_count == CntW'(DEPTH));
    end

    // Next-state and write-port control; flush overrides any push/pop.
    always_comb begin
        w_sp_nxt        = r_sp;
        w_count_nxt     = r_count;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_we            = 1'b0;
        w_waddr         = r_sp;
        if (i_flush) begin
            w_sp_nxt        = '0;
            w_count_nxt     = '0;
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end else begin
            unique case (w_op)
                PUSH: begin
                    w_we     = 1'b1;
                    w_sp_nxt = r_sp + PtrW'(1);
                    // When full the write lands on the oldest slot via wrap-around.
                    if (w_full) begin
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + CntW'(1);
                    end
                end
                POP: begin
                    if (w_empty) begin
                        w_underflow_nxt = 1'b1;
                    end else begin
                        w_sp_nxt    = w_sp_m1;
                        w_count_nxt = r_count - CntW'(1);
                    end
                end
                REPLACE: begin
                    w_we = 1'b1;
                    // Empty stack: nothing to replace, so act as a plain push.
                    if (w_empty) begin
                        w_sp_nxt    = r_sp + PtrW'(1);
                        w_count_nxt = CntW'(1);
                    end else begin
                        w_waddr = w_sp_m1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer, count and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // Outputs; stale entries are masked while empty.
    always_comb begin
        o_top_addr  = w_empty ? '0 : w_rdata;
        o_empty     = w_empty;
        o_full      = w_full;
        o_count     = r_count;
        o_overflow  = r_overflow;
        o_underflow = r_underflow;
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack against a queue-based model.
`timescale 1ns/1ps
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             push;
    logic [WIDTH-1:0] push_addr;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] top_addr;
    logic             empty;
    logic             full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks;
    int n_errors;

    // Reference model: youngest entry at the back of the queue.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    logic             m_unf;

    return_addr_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (push),
        .i_push_addr (push_addr),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_top_addr  (top_addr),
        .o_empty     (empty),
        .o_full      (full),
        .o_count     (count),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] m_top();
        if (m_q.size() == 0) return '0;
        return m_q[m_q.size() - 1];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic f,
                              input logic [WIDTH-1:0] a);
        if (f) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (p && o) begin
            if (m_q.size() == 0) m_q.push_back(a);
            else m_q[m_q.size() - 1] = a;
        end else if (p) begin
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            m_q.push_back(a);
        end else if (o) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else void'(m_q.pop_back());
        end
    endtask

    // Apply one cycle of stimulus, return 1ns after the edge with inputs idle.
    task automatic drive_cycle(input logic p, input logic o, input logic f,
                               input logic [WIDTH-1:0] a);
        push = p; pop = o; flush = f; push_addr = a;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; push_addr = '0;
        model_step(p, o, f, a);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (top_addr !== '0 || empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: top=%h empty=%b full=%b count=%0d ovf=%b unf=%b, want 0 1 0 0 0 0",
                     top_addr, empty, full, count, overflow, underflow);
        end
    endtask

    task automatic test_lifo();
        logic [WIDTH-1:0] exp_top [4];
        exp_top[0] = 32'h30; exp_top[1] = 32'h20; exp_top[2] = 32'h10; exp_top[3] = 32'h0;
        apply_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h10);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h20);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h30);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (top_addr !== exp_top[i] || count !== 4'(3 - i)) begin
                n_errors++;
                $display("FAIL lifo_step%0d: top=%h count=%0d, want top=%h count=%0d",
                         i, top_addr, count, exp_top[i], 3 - i);
            end
            if (i < 3) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL lifo_end: empty=%b unf=%b, want 1 0", empty, underflow);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
        n_checks++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1 || top_addr !== 32'h108) begin
            n_errors++;
            $display("FAIL ovf_full: full=%b count=%0d ovf=%b top=%h, want 1 8 1 108",
                     full, count, overflow, top_addr);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (top_addr !== 32'h108 - 32'(i)) begin
                n_errors++;
                $display("FAIL ovf_pop%0d: top=%h, want %h", i, top_addr, 32'h108 - 32'(i));
            end
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (underflow !== 1'b1 || top_addr !== '0 || empty !== 1'b1 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL unf_ninth_pop: unf=%b top=%h empty=%b ovf=%b, want 1 0 1 1",
                     underflow, top_addr, empty, overflow);
        end
    endtask

    task automatic test_replace();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h40);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h50);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h60);
        n_checks++;
        if (count !== 4'd2 || top_addr !== 32'h60 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL replace_top: count=%0d top=%h ovf=%b, want 2 60 0",
                     count, top_addr, overflow);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (top_addr !== 32'h40 || count !== 4'd1) begin
            n_errors++;
            $display("FAIL replace_pop: top=%h count=%0d, want 40 1", top_addr, count);
        end
        apply_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 32'hABCD);
        n_checks++;
        if (count !== 4'd1 || top_addr !== 32'hABCD || underflow !== 1'b0 || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL replace_empty: count=%0d top=%h unf=%b empty=%b, want 1 abcd 0 0",
                     count, top_addr, underflow, empty);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (count !== 4'd5 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_setup: count=%0d ovf=%b, want 5 1", count, overflow);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 32'hDEAD);
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || top_addr !== '0) begin
            n_errors++;
            $display("FAIL flush_push: count=%0d empty=%b ovf=%b top=%h, want 0 1 0 0",
                     count, empty, overflow, top_addr);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h77);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h88);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (top_addr !== '0 || empty !== 1'b1 || count !== 4'd0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: top=%h empty=%b count=%0d unf=%b, want 0 1 0 0",
                     top_addr, empty, count, underflow);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic p, o, f;
        logic [WIDTH-1:0] a;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 3);
            a = $urandom;
            drive_cycle(p, o, f, a);
            n_checks++;
            if (top_addr !== m_top() || count !== 4'(m_q.size()) ||
                empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH) ||
                overflow !== m_ovf || underflow !== m_unf) begin
                n_errors++;
                $display("FAIL random_cyc%0d: top=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, want top=%h cnt=%0d ovf=%b unf=%b",
                         i, top_addr, count, empty, full, overflow, underflow,
                         m_top(), m_q.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; push_addr = '0;
        model_reset();
        test_reset();
        test_lifo();
        test_overflow();
        test_replace();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
